// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind uart_rx: sync hunt, length/payload/checksum parse, buffered drain.
// Optional inter-word timeout enabled by defining UART_RX_PKT_TIMEOUT_EN.
module uart_rx_pkt_ctrl #(
    parameter int               WIDTH         = 8,
    parameter int               MAX_LEN       = 16,
    parameter logic [WIDTH-1:0] SYNC_WORD     = 'hA5,
    parameter int               TIMEOUT_TICKS = 480
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx_ready,
    input  logic [WIDTH-1:0] rx_data,
    output logic             rx_can_receive,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [1:0]       err_code
);

    localparam int               IDXW      = $clog2(MAX_LEN + 1);
    localparam int               AW        = $clog2(MAX_LEN);
    localparam logic [WIDTH-1:0] MAX_LEN_W = WIDTH'(MAX_LEN);

    if (MAX_LEN < 2 || TIMEOUT_TICKS < 2 || WIDTH < IDXW) begin : g_bad_param
        $error("uart_rx_pkt_ctrl: unsupported parameter combination");
    end

    // states: HUNT seek sync | LEN length word | PAYLOAD store words | CSUM check sum | DRAIN stream out
    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CSUM, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [IDXW-1:0]   len_q, wr_idx, rd_idx, wr_next, rd_next;
    logic [WIDTH-1:0]  sum_q, csum_total;
    logic [WIDTH-1:0]  pkt_mem [MAX_LEN];
    logic              ok_nxt, err_nxt;
    logic [1:0]        code_nxt;
    logic              accept, handshake, active, timeout;

    assign rx_can_receive = (state != DRAIN);
    assign accept         = rx_ready && rx_can_receive;
    assign out_valid      = (state == DRAIN);
    assign handshake      = out_valid && out_ready;
    assign wr_next        = wr_idx + IDXW'(1);
    assign rd_next        = rd_idx + IDXW'(1);
    assign csum_total     = sum_q + rx_data;
    assign out_data       = out_valid ? pkt_mem[rd_idx[AW-1:0]] : '0;
    assign out_last       = out_valid && (rd_next == len_q);
    assign active         = (state == LEN) || (state == PAYLOAD) || (state == CSUM);

`ifdef UART_RX_PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] timer;

    // Down-counter reloaded on every accepted word (including the sync that enters LEN).
    always_ff @(posedge clock) begin
        if (reset) begin
            timer <= '0;
        end else if (accept) begin
            timer <= TW'(TIMEOUT_TICKS);
        end else if (active) begin
            timer <= timer - TW'(1);
        end
    end

    assign timeout = active && !accept && (timer == TW'(1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = err_code;
        case (state)
            HUNT: begin
                if (accept && rx_data == SYNC_WORD) state_nxt = LEN;
            end
            LEN: begin
                if (accept) begin
                    if (rx_data == '0 || rx_data > MAX_LEN_W) begin
                        state_nxt = HUNT;
                        err_nxt   = 1'b1;
                        code_nxt  = 2'd1;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end else if (timeout) begin
                    state_nxt = HUNT;
                    err_nxt   = 1'b1;
                    code_nxt  = 2'd3;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (wr_next == len_q) state_nxt = CSUM;
                end else if (timeout) begin
                    state_nxt = HUNT;
                    err_nxt   = 1'b1;
                    code_nxt  = 2'd3;
                end
            end
            CSUM: begin
                if (accept) begin
                    if (csum_total == '0) begin
                        state_nxt = DRAIN;
                        ok_nxt    = 1'b1;
                    end else begin
                        state_nxt = HUNT;
                        err_nxt   = 1'b1;
                        code_nxt  = 2'd2;
                    end
                end else if (timeout) begin
                    state_nxt = HUNT;
                    err_nxt   = 1'b1;
                    code_nxt  = 2'd3;
                end
            end
            DRAIN: begin
                if (handshake && out_last) state_nxt = HUNT;
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= HUNT;
            len_q     <= '0;
            sum_q     <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            state     <= state_nxt;
            frame_ok  <= ok_nxt;
            frame_err <= err_nxt;
            err_code  <= code_nxt;
            if (accept && state == LEN) begin
                len_q  <= rx_data[IDXW-1:0];
                sum_q  <= rx_data;
                wr_idx <= '0;
                rd_idx <= '0;
            end
            if (accept && state == PAYLOAD) begin
                sum_q  <= csum_total;
                wr_idx <= wr_next;
            end
            if (handshake) rd_idx <= rd_next;
        end
    end

    // Buffer contents need no reset: out_data is gated by out_valid.
    always_ff @(posedge clock) begin
        if (!reset && accept && state == PAYLOAD) pkt_mem[wr_idx[AW-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: scoreboard of expected payload words popped on each output handshake.
module tb_uart_rx_pkt_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       rx_can_receive, out_valid, out_last, frame_ok, frame_err;
    logic [7:0] out_data;
    logic [1:0] err_code;

    int         n_vec = 0;
    int         n_err = 0;
    int         ok_cnt = 0;
    int         err_cnt = 0;
    int         err_base;
    logic [8:0] exp_q[$];
    logic [8:0] e;

    uart_rx_pkt_ctrl dut (
        .clock(clock), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_can_receive(rx_can_receive), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .frame_ok(frame_ok),
        .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] w);
        rx_data  = w;
        rx_ready = 1'b1;
        @(posedge clock);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $error("FAIL sb_empty observed=%0h expected=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", {24'b0, out_data}, {24'b0, e[7:0]});
                    check("sb_last", {31'b0, out_last}, {31'b0, e[8]});
                end
            end
            if (frame_ok) ok_cnt++;
            if (frame_err) err_cnt++;
            if (frame_ok || frame_err) check("ok_err_excl", {31'b0, frame_ok & frame_err}, 32'd0);
        end
    end

    initial begin
        // reset values
        repeat (2) @(posedge clock);
        #1;
        check("rst_can_rx", {31'b0, rx_can_receive}, 32'd1);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_last", {31'b0, out_last}, 32'd0);
        check("rst_data", {24'b0, out_data}, 32'd0);
        check("rst_ok", {31'b0, frame_ok}, 32'd0);
        check("rst_err", {31'b0, frame_err}, 32'd0);
        check("rst_code", {30'b0, err_code}, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        idle(1);

        // good frame, full throughput
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b0, 8'h20});
        exp_q.push_back({1'b1, 8'h30});
        send(8'hA5); send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'h9D);
        check("g1_ok_pulse", {31'b0, frame_ok}, 32'd1);
        check("g1_valid", {31'b0, out_valid}, 32'd1);
        check("g1_first", {24'b0, out_data}, 32'h10);
        check("g1_can_rx", {31'b0, rx_can_receive}, 32'd0);
        idle(4);
        check("g1_drained", exp_q.size(), 32'd0);
        check("g1_ok_cnt", ok_cnt, 32'd1);
        check("g1_err_cnt", err_cnt, 32'd0);
        check("g1_can_rx_after", {31'b0, rx_can_receive}, 32'd1);

        // bad checksum, then a good frame
        send(8'hA5); send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'h9C);
        check("cs_err_pulse", {31'b0, frame_err}, 32'd1);
        check("cs_code", {30'b0, err_code}, 32'd2);
        check("cs_valid", {31'b0, out_valid}, 32'd0);
        exp_q.push_back({1'b1, 8'h42});
        send(8'hA5); send(8'h01); send(8'h42); send(8'hBD);
        idle(3);
        check("cs_drained", exp_q.size(), 32'd0);
        check("cs_ok_cnt", ok_cnt, 32'd2);
        check("cs_err_cnt", err_cnt, 32'd1);

        // length 0 and MAX_LEN+1
        send(8'hA5); send(8'h00);
        check("len0_err", {31'b0, frame_err}, 32'd1);
        check("len0_code", {30'b0, err_code}, 32'd1);
        send(8'hA5); send(8'h11);
        check("len17_err", {31'b0, frame_err}, 32'd1);
        check("len17_code", {30'b0, err_code}, 32'd1);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
        send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'hCB);
        idle(3);
        check("len_drained", exp_q.size(), 32'd0);
        check("len_err_cnt", err_cnt, 32'd3);
        check("len_ok_cnt", ok_cnt, 32'd3);

        // garbage before sync, downstream stall with rx_ready pulses ignored
        out_ready = 1'b0;
        exp_q.push_back({1'b1, 8'h42});
        send(8'h55); send(8'h77); send(8'hA5); send(8'h01); send(8'h42); send(8'hBD);
        check("st_can_rx", {31'b0, rx_can_receive}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                rx_data  = 8'hA5;
                rx_ready = 1'b1;
            end
            @(posedge clock);
            #1;
            rx_ready = 1'b0;
            check("st_valid", {31'b0, out_valid}, 32'd1);
            check("st_data", {24'b0, out_data}, 32'h42);
            check("st_last", {31'b0, out_last}, 32'd1);
            check("st_can_rx_hold", {31'b0, rx_can_receive}, 32'd0);
        end
        out_ready = 1'b1;
        idle(1);
        check("st_release_valid", {31'b0, out_valid}, 32'd0);
        check("st_release_can_rx", {31'b0, rx_can_receive}, 32'd1);
        check("st_drained", exp_q.size(), 32'd0);
        check("st_err_cnt", err_cnt, 32'd3);
        idle(2);

        // reset mid-frame
        err_base = err_cnt;
        send(8'hA5); send(8'h03); send(8'h10); send(8'h20);
        reset = 1'b1;
        idle(1);
        check("mr_can_rx", {31'b0, rx_can_receive}, 32'd1);
        check("mr_valid", {31'b0, out_valid}, 32'd0);
        check("mr_data", {24'b0, out_data}, 32'd0);
        check("mr_code", {30'b0, err_code}, 32'd0);
        check("mr_pulses", {30'b0, frame_ok, frame_err}, 32'd0);
        reset = 1'b0;
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b0, 8'h20});
        exp_q.push_back({1'b1, 8'h30});
        send(8'hA5); send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'h9D);
        check("mr_ok_pulse", {31'b0, frame_ok}, 32'd1);
        idle(4);
        check("mr_drained", exp_q.size(), 32'd0);
        check("mr_no_err", err_cnt, err_base);

        // inter-word idle
        err_base = err_cnt;
        send(8'hA5); send(8'h02); send(8'h11);
        idle(500);
`ifdef UART_RX_PKT_TIMEOUT_EN
        check("to_err_cnt", err_cnt, err_base + 1);
        check("to_code", {30'b0, err_code}, 32'd3);
        check("to_can_rx", {31'b0, rx_can_receive}, 32'd1);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
        send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'hCB);
`else
        check("to_no_err", err_cnt, err_base);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
        send(8'h22); send(8'hCB);
`endif
        check("to_ok_pulse", {31'b0, frame_ok}, 32'd1);
        idle(3);
        check("to_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
